// File: rtl/icache_direct_pkg.sv
// Shared types for the direct-mapped instruction cache: word type, address
// split, frame layout and fill FSM states.
package icache_direct_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned ICACHE_SETS  = 16;
  localparam int unsigned ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int unsigned ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_direct_if.sv
// Fetch-side request/response and memory-controller read signals of the icache.
// slave = cache side, master = datapath fetch stage plus memory controller.
interface icache_direct_if;
  import icache_direct_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  flush;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );

endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with a one-word miss fill FSM.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int unsigned SETS = 16
) (
  input  logic CLK,
  input  logic nRST,
  icache_direct_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output word_t hit_count,
  output word_t miss_count
`endif
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  icache_state_t    state_q, state_d;
  logic [29:0]      miss_line_q, miss_line_d;
  logic [SETS-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [SETS];
  word_t            data_q [SETS];

  logic [TAG_W-1:0] req_tag, fill_tag;
  logic [IDX_W-1:0] req_idx, fill_idx;
  logic             lookup_hit;
  logic             miss;
  logic             fill_we;
  logic             ihit;
  word_t            imemload;
  logic             iren;
  word_t            iaddr;
  logic             unused_byte_off;

  assign req_tag         = bus.imemaddr[31:IDX_W+2];
  assign req_idx         = bus.imemaddr[IDX_W+1:2];
  assign fill_tag        = miss_line_q[29:IDX_W];
  assign fill_idx        = miss_line_q[IDX_W-1:0];
  assign unused_byte_off = ^bus.imemaddr[1:0];

  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d     = state_q;
    miss_line_d = miss_line_q;
    valid_d     = valid_q;
    fill_we     = 1'b0;
    miss        = 1'b0;
    ihit        = 1'b0;
    imemload    = '0;
    iren        = 1'b0;
    iaddr       = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.imemREN) begin
          if (lookup_hit) begin
            // a flush suppresses the hit but a genuine hit still does not start a fill
            if (!bus.flush) begin
              ihit     = 1'b1;
              imemload = data_q[req_idx];
            end
          end else begin
            miss        = 1'b1;
            miss_line_d = bus.imemaddr[31:2];
            state_d     = FILL;
          end
        end
      end
      FILL: begin
        iren  = 1'b1;
        iaddr = {miss_line_q, 2'b00};
        if (!bus.iwait) begin
          fill_we           = 1'b1;
          valid_d[fill_idx] = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // flush overrides a same-cycle fill, leaving the new frame invalid
    if (bus.flush) valid_d = '0;
  end

  assign bus.ihit     = ihit;
  assign bus.imemload = imemload;
  assign bus.iREN     = iren;
  assign bus.iaddr    = iaddr;

`ifdef ICACHE_STATS_EN
  word_t hit_count_q, hit_count_d;
  word_t miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q + {31'd0, ihit};
    miss_count_d = miss_count_q + {31'd0, miss};
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      miss_line_q  <= '0;
      valid_q      <= '0;
`ifdef ICACHE_STATS_EN
      hit_count_q  <= '0;
      miss_count_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      miss_line_q  <= miss_line_d;
      valid_q      <= valid_d;
`ifdef ICACHE_STATS_EN
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
`endif
    end
  end

  // tag/data storage carries no reset; validity alone gates lookups
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.iload;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for icache_direct; checks counters too when
// ICACHE_STATS_EN is defined.
module tb_icache_direct;
  import icache_direct_pkg::*;

  logic CLK;
  logic nRST;
  int   checks;
  int   errors;

  icache_direct_if bus ();

`ifdef ICACHE_STATS_EN
  word_t hit_count;
  word_t miss_count;
`endif

  icache_direct #(.SETS(16)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ren, input word_t addr, input logic wt,
                       input word_t load, input logic fl);
    bus.imemREN  = ren;
    bus.imemaddr = addr;
    bus.iwait    = wt;
    bus.iload    = load;
    bus.flush    = fl;
  endtask

  // check outputs mid-cycle, then step to just after the next rising edge
  task automatic look(input string tag, input logic e_hit, input word_t e_load,
                      input logic e_ren, input word_t e_addr);
    @(negedge CLK);
    chk({tag, ".ihit"},     {31'd0, bus.ihit}, {31'd0, e_hit});
    chk({tag, ".imemload"}, bus.imemload,      e_load);
    chk({tag, ".iREN"},     {31'd0, bus.iREN}, {31'd0, e_ren});
    chk({tag, ".iaddr"},    bus.iaddr,         e_addr);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nRST   = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #2;
    chk("rst.ihit",     {31'd0, bus.ihit}, 32'd0);
    chk("rst.imemload", bus.imemload,      32'd0);
    chk("rst.iREN",     {31'd0, bus.iREN}, 32'd0);
    chk("rst.iaddr",    bus.iaddr,         32'd0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // cold miss, zero-wait fill, hit on first cycle back in IDLE
    drive(1'b1, 32'h40, 1'b0, 32'h2001_0005, 1'b0);
    look("miss40", 1'b0, 32'h0, 1'b0, 32'h0);
    look("fill40", 1'b0, 32'h0, 1'b1, 32'h40);
    look("hit40",  1'b1, 32'h2001_0005, 1'b0, 32'h0);

    drive(1'b1, 32'h44, 1'b0, 32'h1111_0044, 1'b0);
    look("miss44",  1'b0, 32'h0, 1'b0, 32'h0);
    look("fill44",  1'b0, 32'h0, 1'b1, 32'h44);
    look("hit44",   1'b1, 32'h1111_0044, 1'b0, 32'h0);
    look("hit44b",  1'b1, 32'h1111_0044, 1'b0, 32'h0);

    // 0x440 shares index 0 with 0x40 and evicts it
    drive(1'b1, 32'h440, 1'b0, 32'hAAAA_0440, 1'b0);
    look("miss440", 1'b0, 32'h0, 1'b0, 32'h0);
    look("fill440", 1'b0, 32'h0, 1'b1, 32'h440);
    look("hit440",  1'b1, 32'hAAAA_0440, 1'b0, 32'h0);
    drive(1'b1, 32'h40, 1'b0, 32'h2001_0005, 1'b0);
    look("remiss40", 1'b0, 32'h0, 1'b0, 32'h0);

    // redirect during a stalled fill: address stays latched
    drive(1'b1, 32'h80, 1'b1, 32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 5; i++) look("wait40", 1'b0, 32'h0, 1'b1, 32'h40);
    drive(1'b1, 32'h80, 1'b0, 32'h2001_0005, 1'b0);
    look("fillend40", 1'b0, 32'h0, 1'b1, 32'h40);
    drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    look("post40", 1'b1, 32'h2001_0005, 1'b0, 32'h0);
    drive(1'b1, 32'h80, 1'b0, 32'h8080_8080, 1'b0);
    look("miss80", 1'b0, 32'h0, 1'b0, 32'h0);
    look("fill80", 1'b0, 32'h0, 1'b1, 32'h80);
    look("hit80",  1'b1, 32'h8080_8080, 1'b0, 32'h0);
    drive(1'b1, 32'h44, 1'b0, 32'h0, 1'b0);
    look("keep44", 1'b1, 32'h1111_0044, 1'b0, 32'h0);

    // flush on the fill-completion cycle leaves the frame invalid
    drive(1'b1, 32'h40, 1'b0, 32'h2001_0005, 1'b0);
    look("miss40c", 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 32'h40, 1'b0, 32'h2001_0005, 1'b1);
    look("flushfill", 1'b0, 32'h0, 1'b1, 32'h40);
    drive(1'b1, 32'h40, 1'b0, 32'h2001_0005, 1'b0);
    look("pflush40",  1'b0, 32'h0, 1'b0, 32'h0);
    look("refill40",  1'b0, 32'h0, 1'b1, 32'h40);
    drive(1'b1, 32'h44, 1'b0, 32'h1111_0044, 1'b0);
    look("pflush44",  1'b0, 32'h0, 1'b0, 32'h0);
    look("refill44",  1'b0, 32'h0, 1'b1, 32'h44);
    look("hit44c",    1'b1, 32'h1111_0044, 1'b0, 32'h0);

    // flush while a lookup would hit: ihit forced low, then miss
    drive(1'b1, 32'h44, 1'b0, 32'h1111_0044, 1'b1);
    look("flushhit",   1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 32'h44, 1'b1, 32'h1111_0044, 1'b0);
    look("afterflush", 1'b0, 32'h0, 1'b0, 32'h0);

    // asynchronous reset abandons the fill immediately
    @(negedge CLK);
    chk("midfill.iREN", {31'd0, bus.iREN}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("arst.iREN",  {31'd0, bus.iREN}, 32'd0);
    chk("arst.iaddr", bus.iaddr,         32'd0);
`ifdef ICACHE_STATS_EN
    chk("arst.hit_count",  hit_count,  32'd0);
    chk("arst.miss_count", miss_count, 32'd0);
`endif
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // one miss then three hits
    drive(1'b1, 32'h40, 1'b0, 32'h1234_5678, 1'b0);
    look("s.miss", 1'b0, 32'h0, 1'b0, 32'h0);
    look("s.fill", 1'b0, 32'h0, 1'b1, 32'h40);
    for (int i = 0; i < 3; i++) look("s.hit", 1'b1, 32'h1234_5678, 1'b0, 32'h0);
    drive(1'b0, 32'h40, 1'b0, 32'h0, 1'b0);
    look("s.idle", 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef ICACHE_STATS_EN
    chk("s.hit_count",  hit_count,  32'd3);
    chk("s.miss_count", miss_count, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
